// File: rtl/reg_bus_sequencer_pkg.sv
// Shared definitions for the register-bus sequencer: instruction modes, FSM states,
// save-data mux encodings, condition codes and special register indices.
package reg_bus_sequencer_pkg;

  localparam int NUM_REGS = 6;
  localparam int DATA_W   = 8;

  localparam logic [1:0] MODE_IMM  = 2'b00;
  localparam logic [1:0] MODE_CALC = 2'b01;
  localparam logic [1:0] MODE_COPY = 2'b10;
  localparam logic [1:0] MODE_COND = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_IMM  = 2'd0;
  localparam logic [1:0] SEL_ALU  = 2'd1;
  localparam logic [1:0] SEL_BUS1 = 2'd2;
  localparam logic [1:0] SEL_EXT  = 2'd3;

  localparam logic [2:0] COND_NEVER  = 3'd0;
  localparam logic [2:0] COND_EQZ    = 3'd1;
  localparam logic [2:0] COND_LTZ    = 3'd2;
  localparam logic [2:0] COND_LEZ    = 3'd3;
  localparam logic [2:0] COND_ALWAYS = 3'd4;
  localparam logic [2:0] COND_NEZ    = 3'd5;
  localparam logic [2:0] COND_GEZ    = 3'd6;
  localparam logic [2:0] COND_GTZ    = 3'd7;

  // Index 6 is the external input as a COPY source and the output port as a destination.
  localparam logic [2:0] REG_IN   = 3'd6;
  localparam logic [2:0] REG_OUT  = 3'd6;
  localparam logic [2:0] REG_NONE = 3'd7;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [2:0] idx);
    if (idx < 3'(NUM_REGS)) return NUM_REGS'(1) << idx;
    else return '0;
  endfunction

endpackage

// File: rtl/reg_bus_sequencer_if.sv
// Instruction fetch handshake, external I/O handshakes and the bus-1 value
// used by the sequencer for condition evaluation.
interface reg_bus_sequencer_if;
  import reg_bus_sequencer_pkg::*;

  // All handshakes: a transfer happens on a clock edge where valid and ready are both
  // high; valid may not drop and its data may not change until that edge.
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] bus1_data;
  logic              in_valid;
  logic              in_ready;
  logic              out_ready;
  logic              out_valid;

  modport master (
    output instr, instr_valid, bus1_data, in_valid, out_ready,
    input  instr_ready, in_ready, out_valid
  );

  modport slave (
    input  instr, instr_valid, bus1_data, in_valid, out_ready,
    output instr_ready, in_ready, out_valid
  );
endinterface

// File: rtl/reg_bus_sequencer_cond_eval.sv
// Combinational jump-condition evaluator on a signed bus value.
module reg_bus_sequencer_cond_eval
  import reg_bus_sequencer_pkg::*;
(
  input  logic signed [DATA_W-1:0] value,
  input  logic        [2:0]        code,
  output logic                     taken
);
  logic zero;
  logic neg;

  assign zero = (value == '0);
  assign neg  = value[DATA_W-1];

  always_comb begin
    taken = 1'b0;
    case (code)
      COND_NEVER:  taken = 1'b0;
      COND_EQZ:    taken = zero;
      COND_LTZ:    taken = neg;
      COND_LEZ:    taken = neg | zero;
      COND_ALWAYS: taken = 1'b1;
      COND_NEZ:    taken = ~zero;
      COND_GEZ:    taken = ~neg;
      COND_GTZ:    taken = ~neg & ~zero;
      default:     taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/reg_bus_sequencer.sv
// Fetch/read/write sequencer driving the register bank enables, save mux, ALU op,
// I/O handshakes and jump strobe from one instruction byte per operation.
module reg_bus_sequencer
  import reg_bus_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  reg_bus_sequencer_if.slave   bus,
  output logic [NUM_REGS-1:0]  load1_en,
  output logic [NUM_REGS-1:0]  load2_en,
  output logic [NUM_REGS-1:0]  save_en,
  output logic [1:0]           save_sel,
  output logic [DATA_W-1:0]    imm,
  output logic [2:0]           alu_op,
  output logic                 jump,
  output logic                 busy,
  output state_t               dbg_state
);
  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [1:0]          mode_q, mode_d;
  logic [2:0]          src_q, dst_q, src_d, dst_d;
  logic [NUM_REGS-1:0] load1_d, load2_d, save_d;
  logic [1:0]          sel_d;
  logic                in_ready_d, out_valid_d;
  logic                cond_taken;

  assign mode_q = ir_q[7:6];
  assign src_q  = ir_q[5:3];
  assign dst_q  = ir_q[2:0];
  assign mode_d = ir_d[7:6];
  assign src_d  = ir_d[5:3];
  assign dst_d  = ir_d[2:0];

  always_comb begin : next_state
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: if (bus.instr_valid) begin
        ir_d    = bus.instr;
        state_d = READ;
      end
      READ:  if (!(mode_q == MODE_COPY && src_q == REG_IN) || bus.in_valid) state_d = WRITE;
      WRITE: if (!(mode_q == MODE_COPY && dst_q == REG_OUT) || bus.out_ready) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are decoded for the state being entered so the registered enables line up with it.
  always_comb begin : next_outputs
    load1_d     = '0;
    load2_d     = '0;
    save_d      = '0;
    sel_d       = SEL_IMM;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    if (state_d != FETCH) begin
      case (mode_d)
        MODE_IMM:  sel_d = SEL_IMM;
        MODE_CALC: begin
          load1_d = reg_onehot(3'd1);
          load2_d = reg_onehot(3'd2);
          sel_d   = SEL_ALU;
        end
        MODE_COPY: begin
          load1_d = reg_onehot(src_d);
          sel_d   = (src_d == REG_IN) ? SEL_EXT : SEL_BUS1;
        end
        default: begin
          load1_d = reg_onehot(3'd3);
          load2_d = reg_onehot(3'd0);
        end
      endcase
    end
    if (state_d == WRITE) begin
      case (mode_d)
        MODE_IMM:  save_d = reg_onehot(3'd0);
        MODE_CALC: save_d = reg_onehot(3'd3);
        MODE_COPY: if (src_d != REG_NONE) save_d = reg_onehot(dst_d);
        default:   save_d = '0;
      endcase
      out_valid_d = (mode_d == MODE_COPY) && (dst_d == REG_OUT);
      in_ready_d  = (state_q == READ) && (mode_d == MODE_COPY) && (src_d == REG_IN);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= FETCH;
      ir_q            <= '0;
      load1_en        <= '0;
      load2_en        <= '0;
      save_en         <= '0;
      save_sel        <= SEL_IMM;
      imm             <= '0;
      alu_op          <= '0;
      bus.in_ready    <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.instr_ready <= 1'b1;
    end else begin
      state_q         <= state_d;
      ir_q            <= ir_d;
      load1_en        <= load1_d;
      load2_en        <= load2_d;
      save_en         <= save_d;
      save_sel        <= sel_d;
      imm             <= DATA_W'(ir_d[5:0]);
      alu_op          <= ir_d[2:0];
      bus.in_ready    <= in_ready_d;
      bus.out_valid   <= out_valid_d;
      bus.instr_ready <= (state_d == FETCH);
    end
  end

  // Bus 1 is only valid in WRITE, one cycle after its load enable, so jump is decided there.
  reg_bus_sequencer_cond_eval u_cond_eval (
    .value (bus.bus1_data),
    .code  (ir_q[2:0]),
    .taken (cond_taken)
  );

  assign jump      = (state_q == WRITE) && (mode_q == MODE_COND) && cond_taken;
  assign busy      = (state_q != FETCH);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Directed testbench for reg_bus_sequencer: per-scenario tasks with inline checks.
module tb_reg_bus_sequencer;
  import reg_bus_sequencer_pkg::*;

  logic                clk;
  logic                rst;
  logic [NUM_REGS-1:0] load1_en, load2_en, save_en;
  logic [1:0]          save_sel;
  logic [DATA_W-1:0]   imm;
  logic [2:0]          alu_op;
  logic                jump, busy;
  state_t              dbg_state;
  int                  checks;
  int                  errors;

  reg_bus_sequencer_if bus();

  reg_bus_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .load1_en  (load1_en),
    .load2_en  (load2_en),
    .save_en   (save_en),
    .save_sel  (save_sel),
    .imm       (imm),
    .alu_op    (alu_op),
    .jump      (jump),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] b);
    bus.instr       = b;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (dbg_state !== FETCH) begin errors++; $display("FAIL reset_state got %0d want %0d", dbg_state, FETCH); end
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_instr_ready got %b want 1", bus.instr_ready); end
    checks++; if ({load1_en, load2_en, save_en} !== '0) begin errors++; $display("FAIL reset_enables got %b want 0", {load1_en, load2_en, save_en}); end
    checks++; if ({imm, alu_op, save_sel, jump, busy, bus.in_ready, bus.out_valid} !== '0) begin errors++; $display("FAIL reset_misc got %h want 0", {imm, alu_op, save_sel, jump, busy, bus.in_ready, bus.out_valid}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_imm();
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL imm_fetch_ready got %b want 1", bus.instr_ready); end
    issue(8'h2A);
    checks++; if (dbg_state !== READ) begin errors++; $display("FAIL imm_read_state got %0d want %0d", dbg_state, READ); end
    checks++; if ({load1_en, load2_en, save_en} !== '0) begin errors++; $display("FAIL imm_read_enables got %b want 0", {load1_en, load2_en, save_en}); end
    checks++; if ({busy, bus.instr_ready} !== 2'b10) begin errors++; $display("FAIL imm_read_busy got %b want 10", {busy, bus.instr_ready}); end
    tick();
    checks++; if (save_en !== 6'b000001) begin errors++; $display("FAIL imm_save_en got %b want 000001", save_en); end
    checks++; if (save_sel !== 2'd0) begin errors++; $display("FAIL imm_save_sel got %0d want 0", save_sel); end
    checks++; if (imm !== 8'h2A) begin errors++; $display("FAIL imm_value got %h want 2a", imm); end
    tick();
    checks++; if (dbg_state !== FETCH) begin errors++; $display("FAIL imm_done_state got %0d want %0d", dbg_state, FETCH); end
    checks++; if ({save_en, busy, bus.instr_ready} !== 8'b00000001) begin errors++; $display("FAIL imm_done_outputs got %b want 00000001", {save_en, busy, bus.instr_ready}); end
  endtask

  task automatic test_calc();
    issue(8'h44);
    checks++; if (load1_en !== 6'b000010) begin errors++; $display("FAIL calc_load1 got %b want 000010", load1_en); end
    checks++; if (load2_en !== 6'b000100) begin errors++; $display("FAIL calc_load2 got %b want 000100", load2_en); end
    checks++; if (save_en !== 6'b000000) begin errors++; $display("FAIL calc_read_save got %b want 000000", save_en); end
    tick();
    checks++; if (save_en !== 6'b001000) begin errors++; $display("FAIL calc_save_en got %b want 001000", save_en); end
    checks++; if ({load1_en, load2_en} !== 12'b000010_000100) begin errors++; $display("FAIL calc_write_loads got %b want 000010000100", {load1_en, load2_en}); end
    checks++; if (save_sel !== 2'd1) begin errors++; $display("FAIL calc_save_sel got %0d want 1", save_sel); end
    checks++; if (alu_op !== 3'd4) begin errors++; $display("FAIL calc_alu_op got %0d want 4", alu_op); end
    tick();
    checks++; if (dbg_state !== FETCH) begin errors++; $display("FAIL calc_done_state got %0d want %0d", dbg_state, FETCH); end
  endtask

  task automatic test_copy_out();
    bus.out_ready = 1'b0;
    issue(8'h8E);
    checks++; if ({load1_en, bus.out_valid} !== 7'b0000100) begin errors++; $display("FAIL copy_out_read got %b want 0000100", {load1_en, bus.out_valid}); end
    tick();
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) bus.out_ready = 1'b1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL copy_out_valid cycle %0d got %b want 1", k, bus.out_valid); end
      checks++; if ({load1_en, save_en} !== 12'b000010_000000) begin errors++; $display("FAIL copy_out_enables cycle %0d got %b want 000010000000", k, {load1_en, save_en}); end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++; if ({bus.out_valid, load1_en} !== 7'b0) begin errors++; $display("FAIL copy_out_release got %b want 0", {bus.out_valid, load1_en}); end
    checks++; if (dbg_state !== FETCH) begin errors++; $display("FAIL copy_out_done_state got %0d want %0d", dbg_state, FETCH); end
  endtask

  task automatic test_copy_in();
    bus.in_valid = 1'b0;
    issue(8'hB5);
    for (int k = 1; k <= 2; k++) begin
      checks++; if (dbg_state !== READ) begin errors++; $display("FAIL copy_in_wait_state cycle %0d got %0d want %0d", k, dbg_state, READ); end
      checks++; if ({load1_en, load2_en, save_en, bus.in_ready} !== '0) begin errors++; $display("FAIL copy_in_wait_outputs cycle %0d got %b want 0", k, {load1_en, load2_en, save_en, bus.in_ready}); end
      tick();
    end
    bus.in_valid = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL copy_in_ready got %b want 1", bus.in_ready); end
    checks++; if (save_en !== 6'b100000) begin errors++; $display("FAIL copy_in_save_en got %b want 100000", save_en); end
    checks++; if (save_sel !== 2'd3) begin errors++; $display("FAIL copy_in_save_sel got %0d want 3", save_sel); end
    tick();
    bus.in_valid = 1'b0;
    checks++; if ({bus.in_ready, save_en} !== 7'b0) begin errors++; $display("FAIL copy_in_done got %b want 0", {bus.in_ready, save_en}); end
  endtask

  task automatic test_copy_reg();
    issue(8'h94);
    checks++; if (load1_en !== 6'b000100) begin errors++; $display("FAIL copy_reg_load1 got %b want 000100", load1_en); end
    tick();
    checks++; if ({save_en, save_sel} !== 8'b010000_10) begin errors++; $display("FAIL copy_reg_save got %b want 01000010", {save_en, save_sel}); end
    tick();
    issue(8'hBC);
    tick();
    checks++; if ({load1_en, save_en, bus.in_ready, bus.out_valid} !== '0) begin errors++; $display("FAIL copy_nosrc_outputs got %b want 0", {load1_en, save_en, bus.in_ready, bus.out_valid}); end
    tick();
    checks++; if (dbg_state !== FETCH) begin errors++; $display("FAIL copy_nosrc_done_state got %0d want %0d", dbg_state, FETCH); end
  endtask

  task automatic test_cond(input logic [7:0] b, input logic [7:0] v, input logic exp_jump);
    bus.bus1_data = v;
    issue(b);
    checks++; if ({load1_en, load2_en, jump} !== 13'b001000_000001_0) begin errors++; $display("FAIL cond_read instr %h got %b want 0010000000010", b, {load1_en, load2_en, jump}); end
    tick();
    checks++; if (jump !== exp_jump) begin errors++; $display("FAIL cond_jump instr %h bus1 %h got %b want %b", b, v, jump, exp_jump); end
    checks++; if (save_en !== 6'b0) begin errors++; $display("FAIL cond_save instr %h got %b want 0", b, save_en); end
    tick();
    checks++; if ({jump, dbg_state} !== {1'b0, FETCH}) begin errors++; $display("FAIL cond_done instr %h got %b want 000", b, {jump, dbg_state}); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    issue(8'h8E);
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid got %b want 1", bus.out_valid); end
    rst = 1'b0;
    tick();
    checks++; if (dbg_state !== FETCH) begin errors++; $display("FAIL midrst_state got %0d want %0d", dbg_state, FETCH); end
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL midrst_instr_ready got %b want 1", bus.instr_ready); end
    checks++; if ({load1_en, load2_en, save_en, jump, busy, bus.out_valid, bus.in_ready} !== '0) begin errors++; $display("FAIL midrst_outputs got %b want 0", {load1_en, load2_en, save_en, jump, busy, bus.out_valid, bus.in_ready}); end
    checks++; if ({imm, alu_op, save_sel} !== '0) begin errors++; $display("FAIL midrst_fields got %h want 0", {imm, alu_op, save_sel}); end
    rst = 1'b1;
    tick();
    checks++; if ({save_en, dbg_state} !== {6'b0, FETCH}) begin errors++; $display("FAIL midrst_after got %b want 0", {save_en, dbg_state}); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b0;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    bus.bus1_data   = '0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_imm();
    test_calc();
    test_copy_out();
    test_copy_in();
    test_copy_reg();
    test_cond(8'hC1, 8'h00, 1'b1);
    test_cond(8'hC1, 8'h05, 1'b0);
    test_cond(8'hC2, 8'hFF, 1'b1);
    test_cond(8'hC7, 8'hFF, 1'b0);
    test_cond(8'hC7, 8'h01, 1'b1);
    test_cond(8'hC3, 8'h00, 1'b1);
    test_cond(8'hC6, 8'h80, 1'b0);
    test_cond(8'hC0, 8'h00, 1'b0);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bus_sequencer.md
Name: reg_bus_sequencer

Overview:
- Control stage directly upstream of the 8-bit register bank. It accepts one instruction byte per operation from program memory over a valid/ready handshake and decodes it.
- It sequences the bank's per-register load1/load2/save enables across a fixed read phase and write phase. The register tri-state outputs are registered, so the read and write phases must land on separate cycles.
- It also drives the save-data mux select, the ALU opcode, the external I/O handshakes and a jump strobe.

Parameters:
- NUM_REGS, 6: number of general registers (reg0..reg5), one enable bit each.
- DATA_W, 8: width of instruction byte, data buses and immediate.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- instr  in  DATA_W  instruction byte from program memory
- instr_valid  in  1  instruction byte available
- instr_ready  out  1  sequencer accepts instruction this cycle
- bus1_data  in  DATA_W  value on register bus 1, used for condition evaluation
- in_valid  in  1  external input byte available
- in_ready  out  1  external input byte consumed this cycle
- out_ready  in  1  external output sink accepts
- out_valid  out  1  bus 1 value is presented to the output port
- load1_en  out  NUM_REGS  one-hot or zero, drive to bank port-1 enables
- load2_en  out  NUM_REGS  one-hot or zero, drive to bank port-2 enables
- save_en  out  NUM_REGS  one-hot or zero, register write enables
- save_sel  out  2  save-data mux select: 0=imm, 1=alu, 2=bus1, 3=ext input
- imm  out  DATA_W  zero-extended 6-bit immediate
- alu_op  out  3  instr[2:0], held for the whole operation
- jump  out  1  single-cycle strobe: PC loads the value on bus 2
- busy  out  1  high in every state except FETCH

Behaviour:
- Instruction format: [7:6] mode, [5:3] src/field, [2:0] dst/op/cond.
- Modes:
  - 00 IMM: reg0 <= {2'b00, instr[5:0]}.
  - 01 CALC: read reg1 on port 1 and reg2 on port 2; write reg3 from the ALU using alu_op = instr[2:0].
  - 10 COPY: src = instr[5:3], dst = instr[2:0].
    - src 0-5 reads that register on port 1; src 6 takes the external input; src 7 is a no-op source.
    - dst 0-5 writes that register; dst 6 drives the output port; dst 7 discards.
  - 11 COND: read reg3 on port 1 and reg0 on port 2; evaluate cond = instr[2:0] on signed bus1_data.
    - Codes: 0 never, 1 ==0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
- FSM states: FETCH, READ, WRITE.
  - FETCH: instr_ready=1, all enables 0. On instr_valid, latch instr and go to READ.
  - READ: assert load1_en/load2_en for exactly one cycle per the decode. Then go to WRITE, except:
    - COPY with src 6: stay in READ (with no load enables) until in_valid.
    - Entering WRITE is required because the bank output is valid one cycle after its load enable.
  - WRITE: keep the READ load enables asserted so the bus stays driven. Then:
    - IMM/CALC/COPY: assert save_en one-hot for one cycle.
    - COPY src 6: in_ready=1 for that one WRITE cycle and save_sel=3. The latched decision is made in READ, but the data is consumed in WRITE.
    - COPY dst 6: out_valid=1; hold WRITE until out_ready, then return to FETCH.
    - COND: jump=1 for one cycle when the condition is true.
    - Otherwise return to FETCH after one cycle.
- Latency: 3 cycles per instruction (FETCH accept, READ, WRITE) with no I/O stalls. Throughput is one instruction per 3 cycles.
- A COPY with src 7 or dst 7 never asserts save_en, and never asserts out_valid/in_ready for the unused side.
- COPY src == dst: legal. The register is rewritten with its own value.
- Reset (rst==0 at a clock edge):
  - State goes to FETCH.
  - All enables, jump, out_valid and in_ready go to 0; imm, alu_op and save_sel go to 0.
  - Mid-operation reset abandons the instruction with no write.
- Enables are registered outputs. load1_en, load2_en and save_en are never more than one-hot each.

Decomposition:
- Shared package holds:
  - mode constants MODE_IMM/CALC/COPY/COND;
  - the 3-state enum;
  - save_sel encodings;
  - condition codes;
  - REG_IN=6 and REG_NONE=7.
- One natural sub-module, cond_eval: combinational, takes 8-bit signed value and 3-bit code, returns true/false.

Test Plan:
- instr=8'h2A (IMM 42) -> READ with no loads; WRITE: save_en=000001, save_sel=0, imm=8'h2A; back in FETCH after 3 cycles.
- instr=8'h44 (CALC op 4) -> READ: load1_en=000010, load2_en=000100; WRITE: save_en=001000, save_sel=1, alu_op=4.
- instr=8'h8E (COPY reg1->out), out_ready low 3 cycles -> out_valid held 4 cycles, load1_en=000010 throughout, no save_en.
- instr=8'hB5 (COPY in->reg5), in_valid asserted 2 cycles late -> in_ready one cycle, save_en=100000, save_sel=3.
- instr=8'hC1 (COND ==0) with bus1_data=0 -> jump one cycle, load2_en=000001. Repeat with bus1_data=8'hFF and cond 2 -> jump; cond 7 -> no jump.
- Assert rst low during a WRITE stalled on out_ready -> next cycle all outputs 0, state FETCH, instr_ready=1.
